// File: rtl/sme_match_collector.sv
// sme_match_collector
// Collects the per-packet rule-ID stream coming out of the Pigasus SME wrapper.
// The IDs of each packet go into a two-bank ping-pong buffer. Each completed
// packet is presented to the RISC-V core as a descriptor plus an indexed read port.
//
// Ports
//   clk, rst          : system clock, synchronous active-high reset
//   match_rules_ID    : rule ID from the SME (0 is a "no match" filler, never stored)
//   match_last        : marks the last ID of the current packet
//   match_valid       : ID valid
//   match_release     : ready toward the SME (transfer = match_valid && match_release)
//   desc_valid        : a completed packet list is presented
//   desc_count        : number of IDs stored for the presented packet
//   desc_overflow     : presented packet had more than MAX_MATCH non-zero IDs
//   desc_release      : core frees the presented bank (ignored while !desc_valid)
//   rd_index, rd_en   : indexed read of the presented bank
//   rd_data           : registered read data, holds when rd_en is low
//   pkt_cnt, ovf_cnt  : wrapping counters of completed / overflowed packets
module sme_match_collector #(
  parameter int MAX_MATCH = 32,
  parameter int CNT_W     = $clog2(MAX_MATCH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      match_rules_ID,
  input  logic             match_last,
  input  logic             match_valid,
  output logic             match_release,
  output logic             desc_valid,
  output logic [CNT_W-1:0] desc_count,
  output logic             desc_overflow,
  input  logic             desc_release,
  input  logic [CNT_W-2:0] rd_index,
  input  logic             rd_en,
  output logic [31:0]      rd_data,
  output logic [31:0]      pkt_cnt,
  output logic [31:0]      ovf_cnt
);

  localparam int               IDX_W = CNT_W - 1;
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_MATCH);

  typedef enum logic {S_FILL, S_WAIT} state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic             r_fb;          // bank being filled
  logic             r_pb;          // bank being presented
  logic [1:0]       r_bf;          // per-bank "holds a completed list"
  logic [CNT_W-1:0] r_wcnt;        // write slot inside the fill bank
  logic             r_ovf;         // current packet already dropped an ID
  logic [CNT_W-1:0] r_cnt [2];
  logic [1:0]       r_bovf;
  logic [31:0]      r_rd_data;
  logic [31:0]      r_pkt_cnt;
  logic [31:0]      r_ovf_cnt;

  // Both banks live in one array; the bank select is the top address bit.
  logic [31:0]      r_mem [2*MAX_MATCH];

  logic             w_xfer;
  logic             w_nz;
  logic             w_room;
  logic             w_store;
  logic             w_beat_ovf;
  logic             w_done;
  logic             w_pkt_ovf;
  logic             w_rel;
  logic [1:0]       w_bf_next;
  logic             w_fb_next;

  assign w_xfer     = match_valid & match_release;
  assign w_nz       = |match_rules_ID;
  assign w_room     = (r_wcnt != C_MAX);
  assign w_store    = w_xfer & w_nz & w_room;
  assign w_beat_ovf = w_xfer & w_nz & ~w_room;
  assign w_done     = w_xfer & match_last;
  // The overflowing beat may be the last beat itself, so fold it in here.
  assign w_pkt_ovf  = r_ovf | w_beat_ovf;
  assign w_rel      = desc_release & r_bf[r_pb];

  // Fill completion and release always touch different banks. The fill side
  // only completes into an empty bank, and release only clears a full one.
  // So both updates can be applied in the same cycle.
  always_comb begin
    w_bf_next = r_bf;
    if (w_done) w_bf_next[r_fb] = 1'b1;
    if (w_rel)  w_bf_next[r_pb] = 1'b0;
    w_fb_next = r_fb ^ w_done;
  end

  // Fill FSM: state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FILL;
    else     r_state <= w_state_next;
  end

  // Fill FSM: next state. WAIT whenever the bank to be filled next is occupied.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FILL: if (w_done && w_bf_next[~r_fb]) w_state_next = S_WAIT;
      S_WAIT: if (!w_bf_next[r_fb])          w_state_next = S_FILL;
      default: w_state_next = S_FILL;
    endcase
  end

  // Fill FSM: outputs. These come from registered state only, so there is no
  // combinational path from match_valid to match_release.
  always_comb begin
    match_release = (r_state == S_FILL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fb      <= 1'b0;
      r_pb      <= 1'b0;
      r_bf      <= 2'b00;
      r_wcnt    <= '0;
      r_ovf     <= 1'b0;
      r_cnt[0]  <= '0;
      r_cnt[1]  <= '0;
      r_bovf    <= 2'b00;
      r_pkt_cnt <= '0;
      r_ovf_cnt <= '0;
    end else begin
      if (w_store)    r_wcnt <= r_wcnt + 1'b1;
      if (w_beat_ovf) r_ovf  <= 1'b1;
      if (w_done) begin
        r_cnt[r_fb]  <= w_store ? (r_wcnt + 1'b1) : r_wcnt;
        r_bovf[r_fb] <= w_pkt_ovf;
        r_wcnt       <= '0;
        r_ovf        <= 1'b0;
        r_pkt_cnt    <= r_pkt_cnt + 32'd1;
        if (w_pkt_ovf) r_ovf_cnt <= r_ovf_cnt + 32'd1;
      end
      r_bf <= w_bf_next;
      r_fb <= w_fb_next;
      if (w_rel) r_pb <= ~r_pb;
    end
  end

  // RAM write port (no reset, so it maps onto block RAM)
  always_ff @(posedge clk) begin
    if (!rst && w_store) r_mem[{r_fb, r_wcnt[IDX_W-1:0]}] <= match_rules_ID;
  end

  // RAM read port, registered; the value holds between strobes
  always_ff @(posedge clk) begin
    if (rst)        r_rd_data <= '0;
    else if (rd_en) r_rd_data <= r_mem[{r_pb, rd_index}];
  end

  assign desc_valid    = r_bf[r_pb];
  assign desc_count    = r_cnt[r_pb];
  assign desc_overflow = r_bovf[r_pb];
  assign rd_data       = r_rd_data;
  assign pkt_cnt       = r_pkt_cnt;
  assign ovf_cnt       = r_ovf_cnt;

endmodule

// File: tb/tb_sme_match_collector.sv
// tb_sme_match_collector
// Directed and randomized stimulus for sme_match_collector.
// The bench keeps a packet-level reference model. Completed packets are kept
// as a FIFO of (count, overflow) entries plus a flat FIFO of the stored IDs.
module tb_sme_match_collector;

  localparam int MAX_MATCH = 32;
  localparam int CNT_W     = $clog2(MAX_MATCH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      match_rules_ID = '0;
  logic             match_last = 1'b0;
  logic             match_valid = 1'b0;
  logic             match_release;
  logic             desc_valid;
  logic [CNT_W-1:0] desc_count;
  logic             desc_overflow;
  logic             desc_release = 1'b0;
  logic [CNT_W-2:0] rd_index = '0;
  logic             rd_en = 1'b0;
  logic [31:0]      rd_data;
  logic [31:0]      pkt_cnt;
  logic [31:0]      ovf_cnt;

  sme_match_collector #(.MAX_MATCH(MAX_MATCH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .match_rules_ID(match_rules_ID), .match_last(match_last),
    .match_valid(match_valid), .match_release(match_release),
    .desc_valid(desc_valid), .desc_count(desc_count),
    .desc_overflow(desc_overflow), .desc_release(desc_release),
    .rd_index(rd_index), .rd_en(rd_en), .rd_data(rd_data),
    .pkt_cnt(pkt_cnt), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [31:0] cur_ids[$];
  bit          cur_ovf = 0;
  int          cnt_q[$];
  bit          ovf_q[$];
  logic [31:0] ids_q[$];
  int          m_pkt = 0;
  int          m_ovf = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    cur_ids.delete(); cnt_q.delete(); ovf_q.delete(); ids_q.delete();
    cur_ovf = 0; m_pkt = 0; m_ovf = 0;
  endtask

  task automatic model_beat(input logic [31:0] id, input bit last);
    if (id != 0) begin
      if (cur_ids.size() < MAX_MATCH) cur_ids.push_back(id);
      else cur_ovf = 1;
    end
    if (last) begin
      cnt_q.push_back(cur_ids.size());
      ovf_q.push_back(cur_ovf);
      foreach (cur_ids[i]) ids_q.push_back(cur_ids[i]);
      cur_ids.delete();
      m_pkt++;
      if (cur_ovf) m_ovf++;
      cur_ovf = 0;
    end
  endtask

  task automatic model_release();
    int n;
    if (cnt_q.size() > 0) begin
      n = cnt_q.pop_front();
      void'(ovf_q.pop_front());
      repeat (n) void'(ids_q.pop_front());
    end
  endtask

  // One beat: wait (bounded) for match_release, then transfer on the next edge.
  task automatic send_beat(input logic [31:0] id, input bit last, input bit rel);
    int guard = 0;
    match_valid = 1'b1;
    match_rules_ID = id;
    match_last = last;
    while (match_release !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) begin
      chk("release_timeout", {31'd0, match_release}, 32'd1);
    end else begin
      desc_release = rel;
      tick();
      if (rel) model_release();
      model_beat(id, last);
    end
    match_valid = 1'b0;
    match_last = 1'b0;
    desc_release = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] ids[$]);
    foreach (ids[i]) send_beat(ids[i], (i == ids.size() - 1), 1'b0);
  endtask

  task automatic check_desc(input string tag);
    chk({tag, ".desc_valid"}, {31'd0, desc_valid}, {31'd0, cnt_q.size() > 0});
    chk({tag, ".match_release"}, {31'd0, match_release}, {31'd0, cnt_q.size() < 2});
    chk({tag, ".pkt_cnt"}, pkt_cnt, m_pkt);
    chk({tag, ".ovf_cnt"}, ovf_cnt, m_ovf);
    if (cnt_q.size() > 0) begin
      chk({tag, ".desc_count"}, {26'd0, desc_count}, cnt_q[0]);
      chk({tag, ".desc_overflow"}, {31'd0, desc_overflow}, {31'd0, ovf_q[0]});
      for (int i = 0; i < cnt_q[0]; i++) begin
        rd_index = 5'(i);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk($sformatf("%s.rd_data[%0d]", tag, i), rd_data, ids_q[i]);
      end
    end
  endtask

  task automatic release_desc();
    desc_release = 1'b1;
    tick();
    desc_release = 1'b0;
    model_release();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q[$];
    logic [31:0] held;
    int len;

    // reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst.desc_valid", {31'd0, desc_valid}, 32'd0);
    chk("rst.desc_count", {26'd0, desc_count}, 32'd0);
    chk("rst.desc_overflow", {31'd0, desc_overflow}, 32'd0);
    chk("rst.rd_data", rd_data, 32'd0);
    chk("rst.pkt_cnt", pkt_cnt, 32'd0);
    chk("rst.ovf_cnt", ovf_cnt, 32'd0);
    rst = 1'b0;
    tick();
    chk("rst.match_release", {31'd0, match_release}, 32'd1);

    // single packet 0x11,0x22,0x33
    q = '{32'h11, 32'h22, 32'h33};
    send_pkt(q);
    chk("p1.desc_valid_next", {31'd0, desc_valid}, 32'd1);
    check_desc("p1");
    held = rd_data;
    rd_index = 5'd0;
    tick();
    chk("p1.rd_hold", rd_data, held);
    release_desc();

    // only a zero ID with last
    q = '{32'h0};
    send_pkt(q);
    check_desc("zero");
    release_desc();

    // overflow: 40 IDs 1..40
    q.delete();
    for (int i = 1; i <= 40; i++) q.push_back(i);
    send_pkt(q);
    check_desc("ovf");
    release_desc();

    // three 2-ID packets without release
    q = '{32'h101, 32'h102};
    send_pkt(q);
    q = '{32'h201, 32'h202};
    send_pkt(q);
    check_desc("bp.A");
    match_valid = 1'b1;
    match_rules_ID = 32'h301;
    repeat (3) begin
      tick();
      chk("bp.stall", {31'd0, match_release}, 32'd0);
    end
    release_desc();
    send_beat(32'h301, 1'b0, 1'b0);
    send_beat(32'h302, 1'b1, 1'b0);
    check_desc("bp.B");
    release_desc();
    check_desc("bp.C");
    release_desc();

    // release coincident with the other bank's last
    q = '{32'h401, 32'h402, 32'h403};
    send_pkt(q);
    send_beat(32'h501, 1'b0, 1'b0);
    send_beat(32'h502, 1'b1, 1'b1);
    check_desc("sim.P2");
    release_desc();
    q = '{32'h601};
    send_pkt(q);
    check_desc("sim.P3");
    release_desc();

    // reset mid-packet
    for (int i = 0; i < 5; i++) send_beat(32'h700 + i, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    tick();
    check_desc("midrst");
    chk("midrst.desc_count", {26'd0, desc_count}, 32'd0);
    q = '{32'h55, 32'h66};
    send_pkt(q);
    check_desc("midrst.next");
    release_desc();

    // randomized packets with random release timing
    for (int p = 0; p < 25; p++) begin
      if (cnt_q.size() == 2 || ($urandom % 2) == 0) begin
        check_desc("rnd");
        release_desc();
      end
      len = $urandom_range(1, 40);
      q.delete();
      for (int b = 0; b < len; b++)
        q.push_back((($urandom % 4) == 0) ? 32'd0 : $urandom);
      send_pkt(q);
    end
    while (cnt_q.size() > 0) begin
      check_desc("drain");
      release_desc();
    end
    check_desc("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sme_match_collector.md
Name: sme_match_collector

Overview:
- Sits directly downstream of the Pigasus SME wrapper.
- Consumes its 32-bit rule-ID stream (match_rules_ID / match_last / match_valid / match_release) and groups the IDs per packet into a two-bank ping-pong buffer.
- Presents each completed packet's match list to the RISC-V core as a descriptor (count, overflow flag) plus an indexed read port.
- Provides backpressure to the SME when both banks are occupied.

Parameters:
- MAX_MATCH, 32, rule-ID slots per bank (power of two, ≥2).
- CNT_W, $clog2(MAX_MATCH)+1, width of count fields.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- match_rules_ID  input  32  rule ID from SME; 0 = "no match" filler
- match_last  input  1  last ID of current packet
- match_valid  input  1  ID valid
- match_release  output  1  ready toward SME; transfer = match_valid && match_release
- desc_valid  output  1  a completed packet list is available
- desc_count  output  CNT_W  IDs stored for presented packet (0..MAX_MATCH)
- desc_overflow  output  1  packet had more than MAX_MATCH non-zero IDs
- desc_release  input  1  core frees presented bank; honoured only when desc_valid
- rd_index  input  CNT_W-1  slot to read in presented bank
- rd_en  input  1  read strobe
- rd_data  output  32  ID at rd_index, registered
- pkt_cnt  output  32  completed packets, wraps
- ovf_cnt  output  32  packets with overflow, wraps

Behaviour:
- Banks 0/1, each MAX_MATCH×32 RAM. Fill pointer fb, present pointer pb, per-bank full flag bf[1:0], per-bank count and overflow registers.
- Fill FSM:
  - FILL: match_release=1 when !bf[fb].
  - On each transfer with ID≠0 and wcnt<MAX_MATCH: write ID at wcnt, increment wcnt.
  - On each transfer with ID≠0 and wcnt==MAX_MATCH: discard the ID, set ovf.
  - ID==0 is never stored.
  - On a transfer with match_last: latch count and ovf into bank fb, set bf[fb], toggle fb, clear wcnt and ovf, increment pkt_cnt. Increment ovf_cnt if ovf or the current beat overflows.
  - If the newly selected bank is full: match_release=0 (WAIT state) until that bank is released.
- Present side: desc_valid = bf[pb]; desc_count and desc_overflow come from bank pb.
  - desc_release && desc_valid: clear bf[pb], toggle pb, next cycle.
  - desc_release with !desc_valid is ignored.
- Simultaneous fill completion and release of the other bank: both take effect; no ordering loss.
- A packet's descriptor becomes visible (desc_valid=1) the cycle after its match_last transfer. Throughput: one ID per cycle.
- rd_data = bank[pb][rd_index] one cycle after rd_en; holds otherwise.
  - rd_index ≥ desc_count returns stale RAM contents (undefined but harmless).
- match_release is a function of registered state only; no combinational path from match_valid.
- Reset values (mid-operation reset discards all partial and stored lists):
  - fb=pb=0, bf=0, wcnt=0, ovf=0, pkt_cnt=ovf_cnt=0
  - desc_valid=0, desc_count=0, desc_overflow=0, rd_data=0
  - match_release=1 the cycle after reset deasserts.

Test Plan:
- Single packet, IDs 0x11,0x22,0x33 (last on 0x33) → desc_valid next cycle, desc_count=3, overflow=0; rd_index 0..2 returns 0x11,0x22,0x33 one cycle after rd_en; pkt_cnt=1.
- Packet with only ID 0 with last → desc_valid=1, desc_count=0, overflow=0.
- MAX_MATCH=32, send 40 non-zero IDs (1..40) → desc_count=32, overflow=1, slot 31 reads 32, ovf_cnt=1.
- Three 2-ID packets, no desc_release → first two presented in sequence; match_release drops after the 2nd last. After one release, the 3rd packet is accepted and no IDs are lost.
- Release asserted in the same cycle as the other bank's match_last → both banks are correctly cycled; descriptors appear in order with the correct counts.
- Reset asserted mid-packet after 5 IDs → desc_valid=0, counters=0; the next packet starts from slot 0.
